// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI mode-0 controller.
package spi_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} spi_state_e;

    localparam int SPI_DATA_W = 8;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/spi_controller_if.sv
// Fabric handshake plus SPI pins; master = controller side, slave = fabric/peripheral side.
interface spi_controller_if #(parameter int DATA_W = spi_pkg::SPI_DATA_W);
    logic              start;
    logic [DATA_W-1:0] din;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] dout;
    logic              ss;
    logic              sck;
    logic              mosi;
    logic              miso;

    modport master (input start, din, miso, output busy, done, dout, ss, sck, mosi);
    modport slave  (output start, din, miso, input busy, done, dout, ss, sck, mosi);
endinterface

// File: rtl/spi_tick_div.sv
// Half-period divider: counts 0..CLK_DIV-1, wraps on terminal count, held at 0 by clear.
module spi_tick_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = cnt_w(CLK_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    output logic             o_tc,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    assign o_tc  = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign o_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr || o_tc) r_cnt <= '0;
        else                      r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: one MSB-first frame per accepted start, all outputs registered.
// Optional back-to-back frames under one ss assertion when SPI_BURST_EN is defined.
module spi_controller
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = 4
) (
    input logic              clk,
    input logic              rst,
    spi_controller_if.master bus
);
    localparam int CNT_W = cnt_w(CLK_DIV);
    localparam int BIT_W = cnt_w(DATA_W);

    if (CLK_DIV < 4) begin : g_bad_div
        $error("spi_controller: CLK_DIV must be >= 4");
    end

    spi_state_e        r_state, w_state;
    logic [DATA_W-1:0] r_tx_sr, w_tx_sr, r_rx_sr, w_rx_sr, r_dout, w_dout;
    logic [BIT_W-1:0]  r_bit_cnt, w_bit_cnt;
    logic              r_ss, w_ss, r_sck, w_sck, r_mosi, w_mosi;
    logic              r_busy, w_busy, r_done, w_done, r_gap2, w_gap2;
    logic [1:0]        r_miso_s;
    logic              w_tc;
    logic [CNT_W-1:0]  w_cnt;

    spi_tick_div #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) u_div (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state == IDLE),
        .o_tc  (w_tc),
        .o_cnt (w_cnt)
    );

    always_comb begin
        w_state   = r_state;
        w_tx_sr   = r_tx_sr;
        w_rx_sr   = r_rx_sr;
        w_bit_cnt = r_bit_cnt;
        w_ss      = r_ss;
        w_sck     = r_sck;
        w_mosi    = r_mosi;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_dout    = r_dout;
        w_gap2    = r_gap2;
        // Sample mid-high: miso sync flops plus responder latency need ~5 cycles after the fall.
        if (r_state == HIGH && w_cnt == CNT_W'(CLK_DIV / 2))
            w_rx_sr = {r_rx_sr[DATA_W-2:0], r_miso_s[1]};
        unique case (r_state)
            IDLE: begin
                if (bus.start && !r_busy) begin
                    w_tx_sr   = bus.din;
                    w_mosi    = bus.din[DATA_W-1];
                    w_ss      = 1'b0;
                    w_busy    = 1'b1;
                    w_bit_cnt = '0;
                    w_state   = SETUP;
                end
            end
            SETUP, LOW: begin
                if (w_tc) begin
                    w_sck   = 1'b1;
                    w_state = HIGH;
                end
            end
            HIGH: begin
                if (w_tc) begin
                    w_sck = 1'b0;
                    if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
`ifdef SPI_BURST_EN
                        if (bus.start) begin
                            w_done    = 1'b1;
                            w_dout    = r_rx_sr;
                            w_tx_sr   = bus.din;
                            w_mosi    = bus.din[DATA_W-1];
                            w_bit_cnt = '0;
                            w_state   = LOW;
                        end else begin
                            w_state = HOLD;
                        end
`else
                        w_state = HOLD;
`endif
                    end else begin
                        w_bit_cnt = r_bit_cnt + 1'b1;
                        w_tx_sr   = {r_tx_sr[DATA_W-2:0], 1'b0};
                        w_mosi    = r_tx_sr[DATA_W-2];
                        w_state   = LOW;
                    end
                end
            end
            HOLD: begin
                if (w_tc) begin
                    w_ss    = 1'b1;
                    w_dout  = r_rx_sr;
                    w_done  = 1'b1;
                    w_gap2  = 1'b0;
                    w_state = GAP;
                end
            end
            GAP: begin
                // Two half-periods, so a frame spans 2*DATA_W+3 half-periods start to idle.
                if (w_tc) begin
                    if (!r_gap2) begin
                        w_gap2 = 1'b1;
                    end else begin
                        w_busy  = 1'b0;
                        w_state = IDLE;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_dout    <= '0;
            r_bit_cnt <= '0;
            r_ss      <= 1'b1;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_gap2    <= 1'b0;
            r_miso_s  <= '0;
        end else begin
            r_state   <= w_state;
            r_tx_sr   <= w_tx_sr;
            r_rx_sr   <= w_rx_sr;
            r_dout    <= w_dout;
            r_bit_cnt <= w_bit_cnt;
            r_ss      <= w_ss;
            r_sck     <= w_sck;
            r_mosi    <= w_mosi;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_gap2    <= w_gap2;
            r_miso_s  <= {r_miso_s[0], bus.miso};
        end
    end

    assign bus.ss   = r_ss;
    assign bus.sck  = r_sck;
    assign bus.mosi = r_mosi;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.dout = r_dout;
endmodule
